// File: rtl/mac_pe_v2.sv
// mac_pe_v2: systolic-array processing element with two dataflows.
// Output-stationary mode accumulates left*top locally and drains the result
// through a chained result bus. Weight-stationary mode multiplies left by a
// double-buffered weight and adds it to the partial sum arriving from above.
// Every sum saturates to the signed accumulator range and raises a sticky flag.
module mac_pe_v2 #(
    parameter int WORD_SIZE = 8,
    parameter int ACC_SIZE  = 2*WORD_SIZE+8,
    parameter int CHAIN_POS = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_in,
    input  logic                 valid_in,
    input  logic [WORD_SIZE-1:0] left_in,
    input  logic [WORD_SIZE-1:0] top_in,
    output logic [WORD_SIZE-1:0] right_out,
    output logic [WORD_SIZE-1:0] bottom_out,
    output logic                 valid_out,
    input  logic                 w_load_in,
    input  logic [WORD_SIZE-1:0] w_data_in,
    input  logic                 w_swap_in,
    input  logic [ACC_SIZE-1:0]  psum_in,
    output logic [ACC_SIZE-1:0]  psum_out,
    output logic                 psum_valid_out,
    input  logic                 drain_in,
    input  logic [ACC_SIZE-1:0]  res_in,
    input  logic                 res_valid_in,
    output logic [ACC_SIZE-1:0]  res_out,
    output logic                 res_valid_out,
    output logic                 sat_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // True when a one-bit-wider sum does not fit in ACC_SIZE signed bits.
    function automatic logic sat_ovf(input logic [ACC_SIZE:0] s);
        return (s[ACC_SIZE] != s[ACC_SIZE-1]);
    endfunction

    // Clamp a one-bit-wider sum to the signed ACC_SIZE range.
    function automatic logic [ACC_SIZE-1:0] sat_val(input logic [ACC_SIZE:0] s);
        logic [ACC_SIZE-1:0] r;
        if (s[ACC_SIZE] != s[ACC_SIZE-1]) begin
            if (s[ACC_SIZE]) begin
                r = {1'b1, {(ACC_SIZE-1){1'b0}}};
            end else begin
                r = {1'b0, {(ACC_SIZE-1){1'b1}}};
            end
        end else begin
            r = s[ACC_SIZE-1:0];
        end
        return r;
    endfunction

    // Operand, weight and control state
    logic signed [WORD_SIZE-1:0] left_r;
    logic signed [WORD_SIZE-1:0] top_r;
    logic signed [WORD_SIZE-1:0] w_shadow_r;
    logic signed [WORD_SIZE-1:0] w_active_r;
    logic                        valid_r;
    logic                        mode_r;
    state_t                      state_r;
    logic [15:0]                 cnt_r;
    logic [ACC_SIZE-1:0]         acc_r;
    logic [ACC_SIZE-1:0]         psum_r;
    logic                        psum_valid_r;
    logic [ACC_SIZE-1:0]         res_r;
    logic                        res_valid_r;
    logic                        sat_r;

    // Datapath nets
    logic signed [WORD_SIZE-1:0]   op_b_s;
    logic signed [2*WORD_SIZE-1:0] prod_s;
    logic [ACC_SIZE:0]             prod_ext_s;
    logic [ACC_SIZE:0]             os_sum_s;
    logic [ACC_SIZE:0]             ws_sum_s;
    logic [ACC_SIZE:0]             drain_sum_s;
    logic                          os_en_s;
    logic                          ws_en_s;

    // Select second operand, form the full-width product and the saturating sums
    always_comb begin
        op_b_s      = top_r;
        prod_s      = '0;
        prod_ext_s  = '0;
        os_sum_s    = '0;
        ws_sum_s    = '0;
        drain_sum_s = '0;
        if (mode_r) begin
            op_b_s = w_active_r;
        end else begin
            op_b_s = top_r;
        end
        prod_s     = left_r * op_b_s;
        prod_ext_s = {{(ACC_SIZE+1-2*WORD_SIZE){prod_s[2*WORD_SIZE-1]}}, prod_s};
        os_sum_s   = {acc_r[ACC_SIZE-1], acc_r} + prod_ext_s;
        ws_sum_s   = {psum_in[ACC_SIZE-1], psum_in} + prod_ext_s;
        if (valid_r) begin
            drain_sum_s = os_sum_s;
        end else begin
            drain_sum_s = {acc_r[ACC_SIZE-1], acc_r};
        end
        os_en_s = valid_r & ~mode_r;
        ws_en_s = valid_r & mode_r;
    end

    // Operand pipeline: capture qualified operands, forward valid every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_r  <= '0;
            top_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_in;
            if (valid_in) begin
                left_r <= left_in;
                top_r  <= top_in;
            end else begin
                left_r <= left_r;
                top_r  <= top_r;
            end
        end
    end

    // Weight double buffer; a swap promotes the shadow value held before this edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_shadow_r <= '0;
            w_active_r <= '0;
        end else begin
            if (w_load_in) begin
                w_shadow_r <= w_data_in;
            end else begin
                w_shadow_r <= w_shadow_r;
            end
            if (w_swap_in) begin
                w_active_r <= w_shadow_r;
            end else begin
                w_active_r <= w_active_r;
            end
        end
    end

    // Weight-stationary partial sum passed to the PE below
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psum_r       <= '0;
            psum_valid_r <= 1'b0;
        end else begin
            if (ws_en_s) begin
                psum_r       <= sat_val(ws_sum_s);
                psum_valid_r <= 1'b1;
            end else begin
                psum_r       <= psum_r;
                psum_valid_r <= 1'b0;
            end
        end
    end

    // Control FSM with accumulator, saturation flag and result drain chain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            mode_r      <= 1'b0;
            cnt_r       <= 16'd0;
            acc_r       <= '0;
            res_r       <= '0;
            res_valid_r <= 1'b0;
            sat_r       <= 1'b0;
        end else begin
            res_valid_r <= 1'b0;
            if (os_en_s) begin
                acc_r <= sat_val(os_sum_s);
            end else begin
                acc_r <= acc_r;
            end
            if ((os_en_s && sat_ovf(os_sum_s)) || (ws_en_s && sat_ovf(ws_sum_s))) begin
                sat_r <= 1'b1;
            end else begin
                sat_r <= sat_r;
            end
            case (state_r)
                ST_IDLE: begin
                    mode_r <= mode_in;
                    if (valid_r) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (drain_in && !mode_r) begin
                        state_r     <= ST_DRAIN;
                        res_r       <= sat_val(drain_sum_s);
                        res_valid_r <= 1'b1;
                        acc_r       <= '0;
                        sat_r       <= 1'b0;
                        cnt_r       <= 16'd0;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_r < 16'(CHAIN_POS)) begin
                        res_r       <= res_in;
                        res_valid_r <= res_valid_in;
                        cnt_r       <= cnt_r + 16'd1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign right_out      = left_r;
    assign bottom_out     = top_r;
    assign valid_out      = valid_r;
    assign psum_out       = psum_r;
    assign psum_valid_out = psum_valid_r;
    assign res_out        = res_r;
    assign res_valid_out  = res_valid_r;
    assign sat_out        = sat_r;

endmodule

// File: tb/tb_mac_pe_v2.sv
// Directed bench for mac_pe_v2 (WORD_SIZE=8, ACC_SIZE=16, CHAIN_POS=2):
// OS accumulate and drain, chain forwarding, WS psum, weight swap, saturation,
// and asynchronous reset in the middle of a drain.
module tb_mac_pe_v2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               mode_in = 1'b0;
    logic               valid_in = 1'b0;
    logic [7:0]         left_in = 8'd0;
    logic [7:0]         top_in = 8'd0;
    logic signed [7:0]  right_out;
    logic signed [7:0]  bottom_out;
    logic               valid_out;
    logic               w_load_in = 1'b0;
    logic [7:0]         w_data_in = 8'd0;
    logic               w_swap_in = 1'b0;
    logic [15:0]        psum_in = 16'd0;
    logic signed [15:0] psum_out;
    logic               psum_valid_out;
    logic               drain_in = 1'b0;
    logic [15:0]        res_in = 16'd0;
    logic               res_valid_in = 1'b0;
    logic signed [15:0] res_out;
    logic               res_valid_out;
    logic               sat_out;

    int n_cmp = 0;
    int n_err = 0;

    mac_pe_v2 #(.WORD_SIZE(8), .ACC_SIZE(16), .CHAIN_POS(2)) dut (
        .clk(clk), .rst(rst), .mode_in(mode_in), .valid_in(valid_in),
        .left_in(left_in), .top_in(top_in), .right_out(right_out),
        .bottom_out(bottom_out), .valid_out(valid_out),
        .w_load_in(w_load_in), .w_data_in(w_data_in), .w_swap_in(w_swap_in),
        .psum_in(psum_in), .psum_out(psum_out), .psum_valid_out(psum_valid_out),
        .drain_in(drain_in), .res_in(res_in), .res_valid_in(res_valid_in),
        .res_out(res_out), .res_valid_out(res_valid_out), .sat_out(sat_out)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset values
        #2 rst = 1'b0;
        #10;
        chk("rst_right", right_out, 32'sd0);
        chk("rst_valid", valid_out, 32'sd0);
        chk("rst_psum", psum_out, 32'sd0);
        chk("rst_psum_v", psum_valid_out, 32'sd0);
        chk("rst_res", res_out, 32'sd0);
        chk("rst_res_v", res_valid_out, 32'sd0);
        chk("rst_sat", sat_out, 32'sd0);
        rst = 1'b1;
        tick();

        // OS: (3,4),(-2,5),(7,7) -> 51
        valid_in = 1'b1; left_in = 8'sd3; top_in = 8'sd4; tick();
        chk("os_right", right_out, 32'sd3);
        chk("os_bottom", bottom_out, 32'sd4);
        chk("os_valid", valid_out, 32'sd1);
        left_in = -8'sd2; top_in = 8'sd5; tick();
        chk("os_right_neg", right_out, -32'sd2);
        left_in = 8'sd7; top_in = 8'sd7; tick();
        valid_in = 1'b0; tick();
        chk("os_valid_low", valid_out, 32'sd0);
        drain_in = 1'b1; tick();
        chk("drain_res", res_out, 32'sd51);
        chk("drain_res_v", res_valid_out, 32'sd1);
        // Chain forwarding: two cycles of res_in, then back to idle
        drain_in = 1'b0; res_in = 16'd1000; res_valid_in = 1'b1; tick();
        chk("fwd1_res", res_out, 32'sd1000);
        chk("fwd1_v", res_valid_out, 32'sd1);
        res_in = 16'd2000; res_valid_in = 1'b0; tick();
        chk("fwd2_res", res_out, 32'sd2000);
        chk("fwd2_v", res_valid_out, 32'sd0);
        res_in = 16'd3000; res_valid_in = 1'b1; tick();
        chk("idle_v", res_valid_out, 32'sd0);
        chk("idle_hold", res_out, 32'sd2000);
        res_in = 16'd0; res_valid_in = 1'b0;

        // Drain with a product in flight; accumulation resumes into cleared acc
        valid_in = 1'b1; left_in = 8'sd2; top_in = 8'sd3; tick();
        left_in = 8'sd4; top_in = 8'sd5; tick();
        left_in = 8'sd1; top_in = 8'sd10; drain_in = 1'b1; tick();
        chk("drain_inflight", res_out, 32'sd26);
        valid_in = 1'b0; tick();
        tick();
        drain_in = 1'b0; tick();
        drain_in = 1'b1; tick();
        chk("idle_drain_ign", res_valid_out, 32'sd0);
        drain_in = 1'b0; valid_in = 1'b1; left_in = 8'sd0; top_in = 8'sd0; tick();
        valid_in = 1'b0; tick();
        drain_in = 1'b1; tick();
        chk("drain_cont_acc", res_out, 32'sd10);
        chk("drain_cont_v", res_valid_out, 32'sd1);
        drain_in = 1'b0; tick(); tick(); tick();

        // OS saturation: 127*127 repeated clamps at 32767
        valid_in = 1'b1; left_in = 8'sd127; top_in = 8'sd127; tick();
        tick();
        tick();
        chk("sat_not_yet", sat_out, 32'sd0);
        tick();
        chk("sat_set", sat_out, 32'sd1);
        valid_in = 1'b0; tick();
        tick();
        chk("sat_sticky", sat_out, 32'sd1);
        drain_in = 1'b1; tick();
        chk("sat_res", res_out, 32'sd32767);
        chk("sat_clr", sat_out, 32'sd0);
        drain_in = 1'b0; tick(); tick(); tick();

        // WS: weight 6, left -3, psum 100 -> 82
        mode_in = 1'b1; tick();
        w_load_in = 1'b1; w_data_in = 8'sd6; tick();
        w_load_in = 1'b0; w_swap_in = 1'b1; tick();
        w_swap_in = 1'b0;
        valid_in = 1'b1; left_in = -8'sd3; psum_in = 16'sd100; tick();
        chk("ws_pv_early", psum_valid_out, 32'sd0);
        valid_in = 1'b0; tick();
        chk("ws_psum", psum_out, 32'sd82);
        chk("ws_pv", psum_valid_out, 32'sd1);
        tick();
        chk("ws_pv_low", psum_valid_out, 32'sd0);
        chk("ws_psum_hold", psum_out, 32'sd82);
        mode_in = 1'b0;

        // Simultaneous load+swap promotes old shadow (2), keeps new data (9)
        psum_in = 16'd0;
        w_load_in = 1'b1; w_data_in = 8'sd2; tick();
        w_data_in = 8'sd9; w_swap_in = 1'b1; tick();
        w_load_in = 1'b0; w_swap_in = 1'b0;
        valid_in = 1'b1; left_in = 8'sd10; tick();
        valid_in = 1'b0; tick();
        chk("ws_promote_old", psum_out, 32'sd20);
        // Swap coinciding with a product uses the old active weight
        valid_in = 1'b1; left_in = 8'sd1; tick();
        w_swap_in = 1'b1; tick();
        chk("ws_swap_old", psum_out, 32'sd2);
        valid_in = 1'b0; w_swap_in = 1'b0; tick();
        chk("ws_swap_new", psum_out, 32'sd9);

        // WS saturation at both ends
        valid_in = 1'b1; left_in = 8'h80; tick();
        left_in = 8'sd127; psum_in = -16'sd32000; tick();
        chk("ws_sat_min", psum_out, -32'sd32768);
        chk("ws_sat_flag", sat_out, 32'sd1);
        valid_in = 1'b0; psum_in = 16'sd32700; tick();
        chk("ws_sat_max", psum_out, 32'sd32767);

        // Asynchronous reset clears everything
        psum_in = 16'd0; left_in = 8'd0; top_in = 8'd0;
        rst = 1'b0; #2;
        chk("rst2_psum", psum_out, 32'sd0);
        chk("rst2_sat", sat_out, 32'sd0);
        chk("rst2_res", res_out, 32'sd0);
        rst = 1'b1; tick();

        // Reset in the middle of a drain abandons it
        valid_in = 1'b1; left_in = 8'sd5; top_in = 8'sd5; tick();
        valid_in = 1'b0; tick();
        drain_in = 1'b1; tick();
        chk("mid_res", res_out, 32'sd25);
        chk("mid_res_v", res_valid_out, 32'sd1);
        drain_in = 1'b0; res_in = 16'd77; res_valid_in = 1'b1;
        rst = 1'b0; #1;
        chk("mid_rst_v", res_valid_out, 32'sd0);
        chk("mid_rst_res", res_out, 32'sd0);
        chk("mid_rst_right", right_out, 32'sd0);
        tick();
        rst = 1'b1; tick();
        chk("post_rst_v1", res_valid_out, 32'sd0);
        tick();
        chk("post_rst_v2", res_valid_out, 32'sd0);
        chk("post_rst_res", res_out, 32'sd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_pe_v2.md
MAC_PE_V2 -- requirements
Module: mac_pe_v2

Interface
REQ-001 Parameter WORD_SIZE, default 8: signed operand width.
REQ-002 Parameter ACC_SIZE, default 2*WORD_SIZE+8: signed accumulator/psum width; SHALL be >= 2*WORD_SIZE.
REQ-003 Parameter CHAIN_POS, default 0: number of upstream PEs on the result drain chain.
REQ-004 Ports SHALL be, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mode_in  in  1  0 = output-stationary (OS), 1 = weight-stationary (WS).
- valid_in  in  1  left_in/top_in qualifier.
- left_in  in  WORD_SIZE  activation operand.
- top_in  in  WORD_SIZE  OS second operand.
- right_out  out  WORD_SIZE  registered left_in.
- bottom_out  out  WORD_SIZE  registered top_in.
- valid_out  out  1  registered valid_in.
- w_load_in  in  1  write w_data_in to shadow weight.
- w_data_in  in  WORD_SIZE  weight value.
- w_swap_in  in  1  copy shadow weight to active weight.
- psum_in  in  ACC_SIZE  WS partial sum from above.
- psum_out  out  ACC_SIZE  WS partial sum downward, registered.
- psum_valid_out  out  1  psum_out qualifier.
- drain_in  in  1  OS: start result drain.
- res_in  in  ACC_SIZE  drain chain data from upstream PE.
- res_valid_in  in  1  res_in qualifier.
- res_out  out  ACC_SIZE  drain chain data, registered.
- res_valid_out  out  1  res_out qualifier.
- sat_out  out  1  sticky saturation flag.

Function
REQ-005 Operand stage: when valid_in=1, left_reg/top_reg SHALL capture left_in/top_in; otherwise hold; valid_out <= valid_in every cycle.
REQ-006 right_out=left_reg, bottom_out=top_reg in both modes.
REQ-007 Product SHALL be the full 2*WORD_SIZE signed product of left_reg and (mode_reg=1 ? w_active : top_reg), sign-extended to ACC_SIZE.
REQ-008 Sums SHALL saturate to signed ACC_SIZE max/min; any saturation SHALL set sat_out, which holds until reset or drain start.
REQ-009 OS: when valid_out=1, acc <= sat(acc + product); result latency from valid_in = 2 cycles.
REQ-010 WS: psum_out <= sat(psum_in + product) and psum_valid_out <= 1 when valid_out=1; else psum_valid_out <= 0 and psum_out holds.
REQ-011 Weights: w_load_in writes w_shadow; w_swap_in writes w_active <= w_shadow (pre-edge value); simultaneous load+swap SHALL promote the old shadow and store the new data in shadow.
REQ-012 A swap coinciding with valid_out=1 SHALL use the old w_active for that cycle's product.
REQ-013 FSM states IDLE, RUN, DRAIN. mode_reg SHALL sample mode_in only in IDLE.
REQ-014 IDLE -> RUN on valid_out=1. RUN -> DRAIN on drain_in=1 with mode_reg=0; drain_in in WS or IDLE SHALL be ignored.
REQ-015 DRAIN entry edge: res_out <= sat(acc + product if valid_out else acc), res_valid_out <= 1, acc <= 0, sat_out <= 0, counter <= 0.
REQ-016 Each further DRAIN cycle (counter 1..CHAIN_POS): res_out <= res_in, res_valid_out <= res_valid_in. After CHAIN_POS forwarding cycles -> IDLE; CHAIN_POS=0 SHALL return to IDLE after one cycle.
REQ-017 Outside DRAIN, res_valid_out SHALL be 0 and res_out SHALL hold.
REQ-018 Accumulation (REQ-009) SHALL continue into the cleared acc during DRAIN; drain_in during DRAIN SHALL be ignored.

Reset
REQ-019 rst=0 SHALL asynchronously clear all registers: outputs 0, acc 0, w_shadow/w_active 0, sat_out 0, mode_reg 0, FSM IDLE; an in-progress drain SHALL be abandoned with no res_valid_out.

Verification
REQ-020 OS, WORD_SIZE=8: (3,4),(-2,5),(7,7) on consecutive cycles, then drain_in -> res_out=51, res_valid_out one cycle, acc=0.
REQ-021 WS: load 6, swap, left_in=-3, psum_in=100 -> psum_out=82, psum_valid_out=1 two cycles after valid_in.
REQ-022 Simultaneous w_load_in(9)+w_swap_in with shadow=2 -> w_active=2, next swap -> 9; mid-stream swap affects only later products.
REQ-023 ACC_SIZE=16: repeated 127*127 in OS -> acc clamps at 32767, sat_out=1; drain clears sat_out.
REQ-024 CHAIN_POS=2: drain -> own result then two cycles of res_in/res_valid_in forwarded, then IDLE.
REQ-025 rst=0 asserted mid-DRAIN -> all outputs 0 immediately, FSM IDLE, no further res_valid_out.
